// File: rtl/frame_minmax_pkg.sv
// ============================================================================
// Module      : frame_minmax_pkg
// Description : Shared types and constants for the per-frame min/max stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package frame_minmax_pkg;

  // Data width of every streamed word.
  localparam int DW = 32;

  // Control states: waiting for word 0, accumulating, holding a result.
  typedef enum logic [1:0] {
    FIRST = 2'd0,
    ACC   = 2'd1,
    OUT   = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/cmp_lteq32.sv
// ============================================================================
// Module      : cmp_lteq32
// Description : Combinational 32-bit unsigned a <= b comparator.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cmp_lteq32
  import frame_minmax_pkg::*;
(
  input  logic [DW-1:0] a_i,
  input  logic [DW-1:0] b_i,
  output logic          lteq_o
);

  // Both operands are unsigned, so the MSB carries magnitude, not sign.
  assign lteq_o = (a_i <= b_i);

endmodule

`default_nettype wire

// File: rtl/frame_minmax32.sv
// ============================================================================
// Module      : frame_minmax32
// Description : Streaming per-frame reduction. Tracks minimum (first
//               occurrence), maximum (last occurrence), word count and an
//               overflow flag, then presents one result beat per frame.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module frame_minmax32
  import frame_minmax_pkg::*;
#(
  parameter int IDX_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [DW-1:0]    s_data,
  input  logic             s_last,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [DW-1:0]    m_min,
  output logic [DW-1:0]    m_max,
  output logic [IDX_W-1:0] m_min_idx,
  output logic [IDX_W-1:0] m_max_idx,
  output logic [IDX_W-1:0] m_count,
  output logic             m_ovf
);

  // Saturation point of the count and index fields.
  localparam logic [IDX_W-1:0] C_CNT_MAX = {IDX_W{1'b1}};
  localparam logic [IDX_W-1:0] C_ONE     = {{(IDX_W-1){1'b0}}, 1'b1};

  state_e             state_q,   state_d;
  logic [DW-1:0]      min_q,     min_d;
  logic [DW-1:0]      max_q,     max_d;
  logic [IDX_W-1:0]   min_idx_q, min_idx_d;
  logic [IDX_W-1:0]   max_idx_q, max_idx_d;
  logic [IDX_W-1:0]   count_q,   count_d;
  logic               ovf_q,     ovf_d;

  logic               w_accept;
  logic               w_min_lteq;
  logic               w_max_lteq;

  // min <= data: when false, the new word is strictly smaller.
  cmp_lteq32 u_min (
    .a_i    (min_q),
    .b_i    (s_data),
    .lteq_o (w_min_lteq)
  );

  // max <= data: when true, the new word becomes (or ties) the maximum.
  cmp_lteq32 u_max (
    .a_i    (max_q),
    .b_i    (s_data),
    .lteq_o (w_max_lteq)
  );

  assign s_ready  = (state_q != OUT);
  assign w_accept = s_valid & s_ready;

  assign m_valid   = (state_q == OUT);
  assign m_min     = min_q;
  assign m_max     = max_q;
  assign m_min_idx = min_idx_q;
  assign m_max_idx = max_idx_q;
  assign m_count   = count_q;
  assign m_ovf     = ovf_q;

  // Next-state and running-extreme update logic.
  always_comb begin
    state_d   = state_q;
    min_d     = min_q;
    max_d     = max_q;
    min_idx_d = min_idx_q;
    max_idx_d = max_idx_q;
    count_d   = count_q;
    ovf_d     = ovf_q;

    case (state_q)
      FIRST: begin
        if (w_accept) begin
          min_d     = s_data;
          max_d     = s_data;
          min_idx_d = '0;
          max_idx_d = '0;
          count_d   = C_ONE;
          ovf_d     = 1'b0;
          state_d   = s_last ? OUT : ACC;
        end
      end
      ACC: begin
        if (w_accept) begin
          // The current count is this word's index; once the count saturates
          // the index saturates with it.
          if (!w_min_lteq) begin
            min_d     = s_data;
            min_idx_d = count_q;
          end
          if (w_max_lteq) begin
            max_d     = s_data;
            max_idx_d = count_q;
          end
          if (count_q == C_CNT_MAX) begin
            ovf_d = 1'b1;
          end else begin
            count_d = count_q + C_ONE;
          end
          if (s_last) begin
            state_d = OUT;
          end
        end
      end
      OUT: begin
        if (m_ready) begin
          state_d = FIRST;
        end
      end
      default: begin
        state_d = FIRST;
      end
    endcase
  end

  // State and result registers; reset discards any partial frame or result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FIRST;
      min_q     <= '0;
      max_q     <= '0;
      min_idx_q <= '0;
      max_idx_q <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      min_q     <= min_d;
      max_q     <= max_d;
      min_idx_q <= min_idx_d;
      max_idx_q <= max_idx_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_frame_minmax32.sv
// ============================================================================
// Module      : tb_frame_minmax32
// Description : Scoreboard bench for frame_minmax32 (IDX_W = 16 and 4).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_frame_minmax32;

  typedef struct packed {
    logic [31:0] mn;
    logic [31:0] mx;
    logic [15:0] mn_idx;
    logic [15:0] mx_idx;
    logic [15:0] cnt;
    logic        ovf;
  } beat_t;

  logic        clk;
  logic        rst_n;

  // Main instance, IDX_W = 16
  logic        s_valid, s_ready, s_last, m_valid, m_ready, m_ovf;
  logic [31:0] s_data, m_min, m_max;
  logic [15:0] m_min_idx, m_max_idx, m_count;

  // Narrow instance, IDX_W = 4, for saturation
  logic        s4_valid, s4_ready, s4_last, m4_valid, m4_ready, m4_ovf;
  logic [31:0] s4_data, m4_min, m4_max;
  logic [3:0]  m4_min_idx, m4_max_idx, m4_count;

  int n_tests = 0;
  int n_fail  = 0;

  beat_t q16[$];
  beat_t q4[$];

  frame_minmax32 #(.IDX_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready),
    .m_min(m_min), .m_max(m_max), .m_min_idx(m_min_idx), .m_max_idx(m_max_idx),
    .m_count(m_count), .m_ovf(m_ovf)
  );

  frame_minmax32 #(.IDX_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s4_valid), .s_ready(s4_ready), .s_data(s4_data), .s_last(s4_last),
    .m_valid(m4_valid), .m_ready(m4_ready),
    .m_min(m4_min), .m_max(m4_max), .m_min_idx(m4_min_idx), .m_max_idx(m4_max_idx),
    .m_count(m4_count), .m_ovf(m4_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  task automatic chk_beat(input string nm, input beat_t act, input beat_t exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual min=%h max=%h mi=%0d xi=%0d cnt=%0d ovf=%0b required min=%h max=%h mi=%0d xi=%0d cnt=%0d ovf=%0b",
               nm, act.mn, act.mx, act.mn_idx, act.mx_idx, act.cnt, act.ovf,
               exp.mn, exp.mx, exp.mn_idx, exp.mx_idx, exp.cnt, exp.ovf);
    end
  endtask

  function automatic beat_t mk(input logic [31:0] mn, input logic [31:0] mx,
                               input int mi, input int xi, input int cnt, input bit ovf);
    beat_t b;
    b.mn = mn; b.mx = mx;
    b.mn_idx = 16'(mi); b.mx_idx = 16'(xi); b.cnt = 16'(cnt); b.ovf = ovf;
    return b;
  endfunction

  // Monitor for the 16-bit instance: every cycle the beat is visible it must
  // match the head of the queue; the entry retires on the handshake.
  always @(negedge clk) begin
    if (rst_n && m_valid) begin
      if (q16.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL beat16_unexpected: actual min=%h max=%h required no beat", m_min, m_max);
      end else begin
        chk_beat("beat16", {m_min, m_max, m_min_idx, m_max_idx, m_count, m_ovf}, q16[0]);
        if (m_ready) void'(q16.pop_front());
      end
    end
  end

  // Monitor for the 4-bit instance.
  always @(negedge clk) begin
    if (rst_n && m4_valid) begin
      if (q4.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL beat4_unexpected: actual min=%h max=%h required no beat", m4_min, m4_max);
      end else begin
        chk_beat("beat4", {m4_min, m4_max, 12'd0, m4_min_idx, 12'd0, m4_max_idx,
                           12'd0, m4_count, m4_ovf}, q4[0]);
        if (m4_ready) void'(q4.pop_front());
      end
    end
  end

  // Offer one word (called at posedge+1) and hold it until accepted.
  task automatic send(input bit narrow, input logic [31:0] d, input bit last);
    bit acc;
    int n;
    n = 0;
    if (narrow) begin s4_valid = 1'b1; s4_data = d; s4_last = last; end
    else        begin s_valid  = 1'b1; s_data  = d; s_last  = last; end
    do begin
      acc = narrow ? s4_ready : s_ready;
      @(posedge clk); #1;
      n++;
    end while (!acc && n < 200);
    if (narrow) begin s4_valid = 1'b0; s4_last = 1'b0; end
    else        begin s_valid  = 1'b0; s_last  = 1'b0; end
    if (!acc) begin
      n_tests++; n_fail++;
      $display("FAIL send_timeout: actual s_ready=0 required 1 within 200 cycles");
    end
    if (last) chk(narrow ? "latency4" : "latency16",
                  {63'd0, narrow ? m4_valid : m_valid}, 64'd1);
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((q16.size() != 0 || q4.size() != 0) && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_q16", 64'(q16.size()), 64'd0);
    chk("drain_q4",  64'(q4.size()),  64'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    s_valid = 0; s_data = '0; s_last = 0; m_ready = 1;
    s4_valid = 0; s4_data = '0; s4_last = 0; m4_ready = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_outputs", {m_min, m_max}, 64'd0);
    chk("rst_fields", {15'd0, m_valid, m_min_idx, m_max_idx, m_count, m_ovf}, 64'd0);
    chk("rst_s_ready", {63'd0, s_ready}, 64'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Ties: min keeps first 3 (idx 1), max moves to last 9 (idx 4).
    q16.push_back(mk(32'd3, 32'd9, 1, 4, 5, 1'b0));
    send(0, 32'd5, 0); send(0, 32'd3, 0); send(0, 32'd9, 0);
    send(0, 32'd3, 0); send(0, 32'd9, 1);
    drain(20);

    // Single-word frames at both extremes.
    q16.push_back(mk(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 1, 1'b0));
    send(0, 32'hFFFF_FFFF, 1);
    q16.push_back(mk(32'h0, 32'h0, 0, 0, 1, 1'b0));
    send(0, 32'h0, 1);
    drain(20);

    // Unsigned MSB boundary, with 10 cycles of back-pressure on the result.
    m_ready = 1'b0;
    q16.push_back(mk(32'h7FFF_FFFF, 32'h8000_0000, 1, 0, 2, 1'b0));
    send(0, 32'h8000_0000, 0); send(0, 32'h7FFF_FFFF, 1);
    s_valid = 1'b1; s_data = 32'h0000_0001; s_last = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("bp_s_ready", {63'd0, s_ready}, 64'd0);
    end
    chk("bp_q_pending", 64'(q16.size()), 64'd1);
    m_ready = 1'b1;
    @(posedge clk); #1;
    s_valid = 1'b0; s_last = 1'b0;
    chk("bp_s_ready_rise", {63'd0, s_ready}, 64'd1);
    drain(20);

    // Reset mid-frame discards the partial frame.
    send(0, 32'd100, 0); send(0, 32'd1, 0); send(0, 32'd200, 0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midrst_m_valid", {63'd0, m_valid}, 64'd0);
    chk("midrst_count", 64'(m_count), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    q16.push_back(mk(32'd2, 32'd7, 1, 0, 2, 1'b0));
    send(0, 32'd7, 0); send(0, 32'd2, 1);
    drain(20);

    // Saturation with IDX_W = 4: 20 ascending words.
    q4.push_back(mk(32'd1, 32'd20, 0, 15, 15, 1'b1));
    for (int i = 1; i <= 20; i++) send(1, 32'(i), (i == 20));
    drain(20);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
